// File: rtl/timeslice_arbiter_if.sv
// Bus between requesters and the time-slice arbiter: request/slice-length
// inputs plus the grant, slice-position and busy outputs.
interface timeslice_arbiter_if #(
   parameter int unsigned N = 3,
   parameter int unsigned M = 4
);
   logic [N-1:0] i_k;
   logic [M-1:0] i_req;
   logic [M-1:0] o_grant;
   logic [N-1:0] o_count;
   logic         o_slice_end;
   logic         o_busy;

   // requester side
   modport master (
      output i_k,
      output i_req,
      input  o_grant,
      input  o_count,
      input  o_slice_end,
      input  o_busy
   );

   // arbiter side
   modport slave (
      input  i_k,
      input  i_req,
      output o_grant,
      output o_count,
      output o_slice_end,
      output o_busy
   );
endinterface

// File: rtl/timeslice_arbiter.sv
// Round-robin arbiter granting one of M requesters for time slices of k cycles,
// with early release when the holder drops its request.
module timeslice_arbiter #(
   parameter int unsigned N = 3,
   parameter int unsigned M = 4
) (
   input  logic                 i_clk,
   input  logic                 i_reset_n,
   timeslice_arbiter_if.slave   bus
);

   localparam int unsigned PW = (M > 1) ? $clog2(M) : 1;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_GRANT = 1'b1
   } state_t;

   state_t        r_state;
   logic [M-1:0]  r_grant;
   logic [N-1:0]  r_count;
   logic [N-1:0]  r_k_lat;
   logic [PW-1:0] r_ptr;
   logic          r_busy;

   state_t        w_nxt_state;
   logic [M-1:0]  w_nxt_grant;
   logic [N-1:0]  w_nxt_count;
   logic [N-1:0]  w_nxt_k_lat;
   logic [PW-1:0] w_nxt_ptr;
   logic          w_nxt_busy;

   logic          w_any_req;
   logic          w_win_found;
   logic [PW-1:0] w_win_idx;
   logic [PW-1:0] w_cand;
   logic [M-1:0]  w_win_onehot;
   logic [N-1:0]  w_k_eff;
   logic          w_holder_req;
   logic          w_slice_end;

   assign w_any_req    = |bus.i_req;
   assign w_k_eff      = (bus.i_k == '0) ? N'(1) : bus.i_k;
   assign w_win_onehot = M'(1) << w_win_idx;

   // Grant is one-hot, so masking the request vector picks the holder's bit.
   assign w_holder_req = |(bus.i_req & r_grant);
   assign w_slice_end  = r_busy & ((r_count == (r_k_lat - N'(1))) | ~w_holder_req);

   // Round-robin search: pointer+1 .. pointer, first set request wins.
   always_comb begin
      w_win_found = 1'b0;
      w_win_idx   = r_ptr;
      w_cand      = r_ptr;
      for (int unsigned off = 1; off <= M; off++) begin
         w_cand = PW'((32'(r_ptr) + off) % M);
         if (!w_win_found && bus.i_req[w_cand]) begin
            w_win_found = 1'b1;
            w_win_idx   = w_cand;
         end
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      w_nxt_state = r_state;
      w_nxt_grant = r_grant;
      w_nxt_count = r_count;
      w_nxt_k_lat = r_k_lat;
      w_nxt_ptr   = r_ptr;
      w_nxt_busy  = r_busy;

      case (r_state)
         S_IDLE: begin
            if (w_any_req) begin
               w_nxt_state = S_GRANT;
               w_nxt_grant = w_win_onehot;
               w_nxt_count = '0;
               w_nxt_k_lat = w_k_eff;
               w_nxt_ptr   = w_win_idx;
               w_nxt_busy  = 1'b1;
            end
         end
         S_GRANT: begin
            if (w_slice_end) begin
               if (w_any_req) begin
                  // back-to-back handoff, no idle cycle
                  w_nxt_state = S_GRANT;
                  w_nxt_grant = w_win_onehot;
                  w_nxt_count = '0;
                  w_nxt_k_lat = w_k_eff;
                  w_nxt_ptr   = w_win_idx;
                  w_nxt_busy  = 1'b1;
               end else begin
                  w_nxt_state = S_IDLE;
                  w_nxt_grant = '0;
                  w_nxt_count = '0;
                  w_nxt_busy  = 1'b0;
               end
            end else begin
               w_nxt_count = r_count + N'(1);
            end
         end
         default: begin
            w_nxt_state = S_IDLE;
            w_nxt_grant = '0;
            w_nxt_count = '0;
            w_nxt_busy  = 1'b0;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state <= S_IDLE;
         r_grant <= '0;
         r_count <= '0;
         r_k_lat <= N'(1);
         r_ptr   <= PW'(M - 1);
         r_busy  <= 1'b0;
      end else begin
         r_state <= w_nxt_state;
         r_grant <= w_nxt_grant;
         r_count <= w_nxt_count;
         r_k_lat <= w_nxt_k_lat;
         r_ptr   <= w_nxt_ptr;
         r_busy  <= w_nxt_busy;
      end
   end

   assign bus.o_grant     = r_grant;
   assign bus.o_count     = r_count;
   assign bus.o_slice_end = w_slice_end;
   assign bus.o_busy      = r_busy;

endmodule

// File: tb/tb_timeslice_arbiter.sv
// Directed-vector bench for timeslice_arbiter; inputs change and outputs are
// sampled on the falling clock edge.
module tb_timeslice_arbiter;

   localparam int unsigned N = 3;
   localparam int unsigned M = 4;

   logic clk;
   logic rst_n;
   int   n_total;
   int   n_pass;

   timeslice_arbiter_if #(.N(N), .M(M)) u_if ();

   timeslice_arbiter #(.N(N), .M(M)) u_dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (u_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp)
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      else
         n_pass++;
   endtask

   // One falling edge, then check all outputs.
   task automatic step_chk(input string tag, input logic [3:0] e_grant,
                           input logic [2:0] e_count, input logic e_se, input logic e_busy);
      @(negedge clk);
      chk({tag, "_grant"}, 32'(u_if.o_grant), 32'(e_grant));
      chk({tag, "_count"}, 32'(u_if.o_count), 32'(e_count));
      chk({tag, "_se"},    32'(u_if.o_slice_end), 32'(e_se));
      chk({tag, "_busy"},  32'(u_if.o_busy), 32'(e_busy));
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      u_if.i_req = '0;
      #2;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_total    = 0;
      n_pass     = 0;
      rst_n      = 1'b0;
      u_if.i_k   = 3'd1;
      u_if.i_req = 4'b0000;
      #3;
      rst_n = 1'b1;

      // Reset / idle
      for (int i = 0; i < 5; i++) step_chk("idle", 4'b0000, 3'd0, 1'b0, 1'b0);

      // Single requester, full slices of 4
      u_if.i_k   = 3'd4;
      u_if.i_req = 4'b0001;
      for (int i = 0; i < 8; i++)
         step_chk("single", 4'b0001, 3'(i % 4), (i % 4) == 3, 1'b1);
      u_if.i_req = 4'b0000;
      step_chk("single_idle", 4'b0000, 3'd0, 1'b0, 1'b0);

      // Round-robin rotation, k=2
      do_reset();
      u_if.i_k   = 3'd2;
      u_if.i_req = 4'b1011;
      step_chk("rr0a", 4'b0001, 3'd0, 1'b0, 1'b1);
      step_chk("rr0b", 4'b0001, 3'd1, 1'b1, 1'b1);
      step_chk("rr1a", 4'b0010, 3'd0, 1'b0, 1'b1);
      step_chk("rr1b", 4'b0010, 3'd1, 1'b1, 1'b1);
      step_chk("rr3a", 4'b1000, 3'd0, 1'b0, 1'b1);
      step_chk("rr3b", 4'b1000, 3'd1, 1'b1, 1'b1);
      step_chk("rr0c", 4'b0001, 3'd0, 1'b0, 1'b1);
      step_chk("rr0d", 4'b0001, 3'd1, 1'b1, 1'b1);

      // k=0 behaves as 1: alternate every cycle
      do_reset();
      u_if.i_k   = 3'd0;
      u_if.i_req = 4'b0110;
      step_chk("k0a", 4'b0010, 3'd0, 1'b1, 1'b1);
      step_chk("k0b", 4'b0100, 3'd0, 1'b1, 1'b1);
      step_chk("k0c", 4'b0010, 3'd0, 1'b1, 1'b1);
      step_chk("k0d", 4'b0100, 3'd0, 1'b1, 1'b1);
      // Early release within a k=5 slice
      u_if.i_k = 3'd5;
      step_chk("er0", 4'b0010, 3'd0, 1'b0, 1'b1);
      step_chk("er1", 4'b0010, 3'd1, 1'b0, 1'b1);
      u_if.i_req = 4'b0100;
      #1;
      chk("er_se_comb", 32'(u_if.o_slice_end), 32'd1);
      step_chk("er_hand", 4'b0100, 3'd0, 1'b0, 1'b1);

      // Mid-slice i_k change is ignored until next slice
      do_reset();
      u_if.i_k   = 3'd3;
      u_if.i_req = 4'b0001;
      step_chk("kc0", 4'b0001, 3'd0, 1'b0, 1'b1);
      step_chk("kc1", 4'b0001, 3'd1, 1'b0, 1'b1);
      u_if.i_k = 3'd6;
      step_chk("kc2", 4'b0001, 3'd2, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++)
         step_chk("kc6", 4'b0001, 3'(i), i == 5, 1'b1);

      // Asynchronous reset mid-slice
      do_reset();
      u_if.i_k   = 3'd4;
      u_if.i_req = 4'b0001;
      step_chk("ar0", 4'b0001, 3'd0, 1'b0, 1'b1);
      step_chk("ar1", 4'b0001, 3'd1, 1'b0, 1'b1);
      step_chk("ar2", 4'b0001, 3'd2, 1'b0, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("ar_grant", 32'(u_if.o_grant), 32'd0);
      chk("ar_busy",  32'(u_if.o_busy), 32'd0);
      chk("ar_count", 32'(u_if.o_count), 32'd0);
      chk("ar_se",    32'(u_if.o_slice_end), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      step_chk("ar_re0", 4'b0001, 3'd0, 1'b0, 1'b1);
      step_chk("ar_re1", 4'b0001, 3'd1, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
